// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and bridge FSM encoding.
// Imported by the command-to-AXI-Lite master bridge.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t WR_REQ  = 3'd1;
  localparam state_t WR_RESP = 3'd2;
  localparam state_t RD_REQ  = 3'd3;
  localparam state_t RD_RESP = 3'd4;
  localparam state_t RSP     = 3'd5;

  // States that wait on a bus handshake and so are timed
  function automatic logic is_busy(input state_t s);
    return (s == WR_REQ) || (s == WR_RESP) ||
           (s == RD_REQ) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI-Lite master: one valid/ready command in,
// one AW/W/B or AR/R transaction out, one response back.
module axi_lite_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,

  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,

  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,

  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,

  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,

  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp
);

  import axi_lite_pkg::*;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              write_q;

  logic aw_left;
  logic w_left;
  logic done;
  logic expire;

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign awprot = 3'b000;
  assign arprot = 3'b000;

  assign aw_left = awvalid && !awready;
  assign w_left  = wvalid && !wready;

  // A state is "done" when its completing handshake fires this cycle
  always_comb begin
    done = 1'b0;
    case (state)
      WR_REQ:  done = !aw_left && !w_left;
      WR_RESP: done = bvalid;
      RD_REQ:  done = arready;
      RD_RESP: done = rvalid;
      default: done = 1'b0;
    endcase
  end

  assign expire = (TIMEOUT != 0) && is_busy(state) &&
                  (cnt == CNT_MAX) && !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      cmd_ready   <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= RESP_OKAY;
      rsp_timeout <= 1'b0;
    end else begin
      if (is_busy(state)) cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            cnt       <= '0;
            if (cmd_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (done) begin
            bready <= 1'b1;
            cnt    <= '0;
            state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            bready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= bresp;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
            state       <= RSP;
          end
        end

        RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            cnt     <= '0;
            state   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (rvalid) begin
            rready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b0;
            rsp_rdata   <= rdata;
            rsp_resp    <= rresp;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
            state       <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Abort: late B/R are never accepted since readies drop here
      if (expire) begin
        awvalid     <= 1'b0;
        wvalid      <= 1'b0;
        arvalid     <= 1'b0;
        bready      <= 1'b0;
        rready      <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_write   <= write_q;
        rsp_rdata   <= '0;
        rsp_resp    <= RESP_SLVERR;
        rsp_timeout <= 1'b1;
        cnt         <= '0;
        state       <= RSP;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge with a small
// 4-register AXI-Lite slave model and configurable stalls.
module tb_axi_lite_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp)
  );

  // Slave model: ready one cycle after valid (plus optional stall)
  logic [31:0] mem [4];
  int          aw_delay = 0;
  int          w_delay  = 0;
  logic        ar_en    = 1'b1;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d, ta, td;
  logic [3:0]  w_s, ts;

  always @(posedge clk) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0;
      bvalid  <= 1'b0; bresp  <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0;
      rdata   <= '0;   rresp  <= 2'b00;
      aw_cnt  <= 0;    w_cnt  <= 0;
      aw_got  <= 1'b0; w_got  <= 1'b0;
      aw_a    <= '0;   w_d    <= '0; w_s <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (awvalid && awready) begin
        awready <= 1'b0; aw_got <= 1'b1;
        aw_a <= awaddr;  aw_cnt <= 0;
      end else if (awvalid && !aw_got) begin
        if (aw_cnt == aw_delay) awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        wready <= 1'b0; w_got <= 1'b1;
        w_d <= wdata;   w_s <= wstrb; w_cnt <= 0;
      end else if (wvalid && !w_got) begin
        if (w_cnt == w_delay) wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if ((aw_got || (awvalid && awready)) &&
          (w_got || (wvalid && wready)) && !bvalid) begin
        ta = aw_got ? aw_a : awaddr;
        td = w_got ? w_d : wdata;
        ts = w_got ? w_s : wstrb;
        for (int i = 0; i < 4; i++)
          if (ts[i]) mem[ta[3:2]][8*i +: 8] <= td[8*i +: 8];
        bvalid <= 1'b1; bresp <= 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= (araddr == 32'h40) ? 32'hBAD0_0040
                                      : mem[araddr[3:2]];
        rresp   <= (araddr == 32'h40) ? 2'b11 : 2'b00;
      end else if (arvalid && ar_en && !rvalid) begin
        arready <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Bus monitors
  int          rsp_cnt = 0, cmd_cnt = 0, ar_cyc = 0;
  int          aw_only = 0, addr_bad = 0;
  logic        prev_aw = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) rsp_cnt++;
    if (cmd_valid && cmd_ready) cmd_cnt++;
    if (arvalid) ar_cyc++;
    if (awvalid && !wvalid) aw_only++;
    if (awvalid && prev_aw && awaddr != prev_addr) addr_bad++;
    prev_aw   = awvalid;
    prev_addr = awaddr;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output int lat, output logic [1:0] resp,
                         output logic [31:0] rd, output logic tmo,
                         output logic wr);
    int t0;
    int n;
    lat = -1; resp = 2'bxx; rd = 'x; tmo = 1'bx; wr = 1'bx;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); n++;
    end
    t0 = cyc;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    if (rsp_valid) begin
      lat = cyc - t0; resp = rsp_resp; rd = rsp_rdata;
      tmo = rsp_timeout; wr = rsp_write;
    end
    if (rsp_ready) @(posedge clk);
  endtask

  int          lat, base, n;
  logic [1:0]  resp;
  logic [31:0] rd;
  logic        tmo, wr;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {awvalid, wvalid, arvalid, bready,
                    rready, rsp_valid, cmd_ready}, '0);
    chk("rst_data", {awaddr, rsp_rdata}, '0);
    chk("rst_rsp", {rsp_resp, rsp_timeout, rsp_write}, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_rdy", cmd_ready, 1'b1);

    // Write then read back, zero-wait slave
    base = rsp_cnt;
    run_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, lat, resp, rd, tmo, wr);
    chk("wr_lat", lat, 4);
    chk("wr_rsp", {resp, tmo, wr}, {2'b00, 1'b0, 1'b1});
    chk("wr_rdata", rd, 32'h0);
    chk("wr_mem", mem[1], 32'hDEADBEEF);
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, resp, rd, tmo, wr);
    chk("rd_lat", lat, 4);
    chk("rd_rsp", {resp, tmo, wr}, {2'b00, 1'b0, 1'b0});
    chk("rd_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("rsp_cnt_a", rsp_cnt - base, 2);

    // AW stalled 3 cycles, W accepted first
    aw_delay = 3;
    base = rsp_cnt; n = aw_only;
    run_cmd(1'b1, 32'h8, 32'h12345678, 4'hF, lat, resp, rd, tmo, wr);
    aw_delay = 0;
    chk("split_lat", lat, 7);
    chk("split_rsp", {resp, tmo, wr}, {2'b00, 1'b0, 1'b1});
    chk("split_awonly", aw_only - n, 3);
    chk("split_addr", addr_bad, 0);
    @(negedge clk);
    chk("split_once", rsp_cnt - base, 1);
    chk("split_mem", mem[2], 32'h12345678);

    // Response back-pressure
    rsp_ready = 1'b0;
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, resp, rd, tmo, wr);
    chk("bp_lat", lat, 4);
    base = cmd_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, cmd_ready}, 2'b10);
      chk("bp_data", rsp_rdata, 32'hDEADBEEF);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_nofire", cmd_cnt - base, 0);
    chk("bp_drop", {rsp_valid, cmd_ready}, 2'b01);
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, lat, resp, rd, tmo, wr);
    chk("bp_next_lat", lat, 4);
    chk("bp_next_data", rd, 32'h12345678);

    // AR never accepted -> timeout after 8 cycles
    ar_en = 1'b0;
    n = ar_cyc;
    run_cmd(1'b0, 32'hC, 32'h0, 4'h0, lat, resp, rd, tmo, wr);
    ar_en = 1'b1;
    chk("to_arcyc", ar_cyc - n, 8);
    chk("to_lat", lat, 9);
    chk("to_rsp", {resp, tmo, wr}, {2'b10, 1'b1, 1'b0});
    chk("to_rdata", rd, 32'h0);
    @(negedge clk);
    chk("to_idle", {arvalid, rready, cmd_ready}, 3'b001);

    // Error response passed through
    base = rsp_cnt;
    run_cmd(1'b0, 32'h40, 32'h0, 4'h0, lat, resp, rd, tmo, wr);
    chk("err_rsp", {resp, tmo}, {2'b11, 1'b0});
    chk("err_data", rd, 32'hBAD0_0040);
    repeat (3) @(negedge clk);
    chk("err_once", rsp_cnt - base, 1);

    // Reset while in WR_RESP
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0;
    cmd_wdata = 32'h11111111; cmd_wstrb = 4'hF;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("g_wrresp", bready, 1'b1);
    base = rsp_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("g_clear", {awvalid, wvalid, arvalid, bready,
                    rready, rsp_valid}, '0);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("g_norsp", rsp_cnt - base, 0);
    chk("g_idle", cmd_ready, 1'b1);
    run_cmd(1'b1, 32'hC, 32'hCAFEF00D, 4'h3, lat, resp, rd, tmo, wr);
    chk("g_wr_lat", lat, 4);
    chk("g_wr_rsp", {resp, tmo, wr}, {2'b00, 1'b0, 1'b1});
    run_cmd(1'b0, 32'hC, 32'h0, 4'h0, lat, resp, rd, tmo, wr);
    chk("g_rd_data", rd, 32'h0000F00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
